// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture and dump blocks.
package la_pkg;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;
    localparam int NCH     = 5;
    localparam int CHW     = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        LATCH   = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4,
        DONE    = 3'd5
    } dump_state_t;

endpackage

// File: rtl/circ_addr_cnt.sv
// Circular address counter over a non-power-of-two depth: load with range clamp,
// increment wrapping from ENTRIES-1 back to 0.
module circ_addr_cnt
    import la_pkg::*;
#(
    parameter int ENTRIES = la_pkg::ENTRIES,
    parameter int LOG2    = la_pkg::LOG2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [LOG2-1:0] load_val,
    input  logic            inc,
    output logic [LOG2-1:0] cnt
);

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
    localparam logic [LOG2-1:0] ZERO = {LOG2{1'b0}};
    localparam logic [LOG2-1:0] ONE  = {{(LOG2-1){1'b0}}, 1'b1};

    logic [LOG2-1:0] cnt_d;
    logic [LOG2-1:0] cnt_q;

    // Next pointer: an out-of-range start address restarts at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            if (load_val > LAST) begin
                cnt_d = ZERO;
            end else begin
                cnt_d = load_val;
            end
        end else if (inc) begin
            if (cnt_q == LAST) begin
                cnt_d = ZERO;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ram_dump_cntrl.sv
// Dumps one channel of the sample RAM to the UART, oldest sample first, while
// sharing the RAM address port with the capture writer (capture wins).
module ram_dump_cntrl
    import la_pkg::*;
#(
    parameter int ENTRIES = la_pkg::ENTRIES,
    parameter int LOG2    = la_pkg::LOG2,
    parameter int NCH     = la_pkg::NCH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dump_start,
    input  logic [2:0]      dump_chan,
    input  logic [LOG2-1:0] cap_addr,
    input  logic            cap_we,
    input  logic [LOG2-1:0] cap_waddr,
    output logic [LOG2-1:0] ram_addr,
    output logic            ram_we,
    output logic            ram_re,
    input  logic [7:0]      ram_rdata,
    output logic [2:0]      ch_sel,
    output logic [7:0]      tx_data,
    output logic            trmt,
    input  logic            tx_done,
    output logic            dump_busy,
    output logic            dump_done,
    output logic            dump_err
);

    localparam logic [LOG2:0] LAST_BYTE = (LOG2+1)'(ENTRIES - 1);
    localparam logic [LOG2:0] CNT_ONE   = {{LOG2{1'b0}}, 1'b1};
    localparam logic [2:0]    NCH_C     = 3'(NCH);

    dump_state_t     state_q,    state_d;
    logic [2:0]      ch_sel_q,   ch_sel_d;
    logic [7:0]      tx_data_q,  tx_data_d;
    logic [LOG2:0]   byte_cnt_q, byte_cnt_d;
    logic            busy_q,     busy_d;
    logic            trmt_q,     trmt_d;
    logic            done_q,     done_d;
    logic            err_q,      err_d;
    logic            ptr_load_s;
    logic            ptr_inc_s;
    logic [LOG2-1:0] rd_ptr_s;

    circ_addr_cnt #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) u_rd_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (ptr_load_s),
        .load_val (cap_addr),
        .inc      (ptr_inc_s),
        .cnt      (rd_ptr_s)
    );

    // Next-state and next-output logic; pulses are staged so they appear registered.
    always_comb begin
        state_d    = state_q;
        ch_sel_d   = ch_sel_q;
        tx_data_d  = tx_data_q;
        byte_cnt_d = byte_cnt_q;
        busy_d     = busy_q;
        trmt_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = dump_start && (state_q != IDLE);
        ptr_load_s = 1'b0;
        ptr_inc_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    if (dump_chan < NCH_C) begin
                        ch_sel_d   = dump_chan;
                        ptr_load_s = 1'b1;
                        byte_cnt_d = {(LOG2+1){1'b0}};
                        busy_d     = 1'b1;
                        state_d    = RD;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (cap_we) begin
                    state_d = RD;
                end else begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                tx_data_d = ram_rdata;
                trmt_d    = 1'b1;
                state_d   = SEND;
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    byte_cnt_d = byte_cnt_q + CNT_ONE;
                    if (byte_cnt_q == LAST_BYTE) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        ptr_inc_s = 1'b1;
                        state_d   = RD;
                    end
                end else begin
                    state_d = WAIT_TX;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_sel_q   <= 3'd0;
            tx_data_q  <= 8'd0;
            byte_cnt_q <= {(LOG2+1){1'b0}};
            busy_q     <= 1'b0;
            trmt_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_sel_q   <= ch_sel_d;
            tx_data_q  <= tx_data_d;
            byte_cnt_q <= byte_cnt_d;
            busy_q     <= busy_d;
            trmt_q     <= trmt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Capture must own the address port in the same cycle it writes.
    assign ram_addr  = cap_we ? cap_waddr : rd_ptr_s;
    assign ram_we    = cap_we;
    assign ram_re    = (state_q == RD) && !cap_we;
    assign ch_sel    = ch_sel_q;
    assign tx_data   = tx_data_q;
    assign trmt      = trmt_q;
    assign dump_busy = busy_q;
    assign dump_done = done_q;
    assign dump_err  = err_q;

endmodule

// File: tb/tb_ram_dump_cntrl.sv
// Directed bench for ram_dump_cntrl with a synchronous RAM model and a UART responder.
module tb_ram_dump_cntrl;

    localparam int N = 384;

    logic       clk = 1'b0;
    logic       rst;
    logic       dump_start;
    logic [2:0] dump_chan;
    logic [8:0] cap_addr;
    logic       cap_we;
    logic [8:0] cap_waddr;
    logic [8:0] ram_addr;
    logic       ram_we;
    logic       ram_re;
    logic [7:0] ram_rdata;
    logic [2:0] ch_sel;
    logic [7:0] tx_data;
    logic       trmt;
    logic       tx_done;
    logic       dump_busy;
    logic       dump_done;
    logic       dump_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] got_q[$];
    int trmt_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int addr_bad = 0;
    int overlap = 0;
    int tx_mode = 0;

    ram_dump_cntrl dut (
        .clk(clk), .rst(rst), .dump_start(dump_start), .dump_chan(dump_chan),
        .cap_addr(cap_addr), .cap_we(cap_we), .cap_waddr(cap_waddr),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
        .ch_sel(ch_sel), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .dump_busy(dump_busy), .dump_done(dump_done), .dump_err(dump_err)
    );

    always #5 clk = ~clk;

    // RAM content: addr[7:0], channel-scrambled so that channel 2 reads back the plain address.
    always @(posedge clk) begin
        if (ram_re === 1'b1) ram_rdata <= ram_addr[7:0] ^ {ch_sel, 5'd0} ^ 8'h40;
    end

    always @(negedge clk) begin
        if (trmt === 1'b1) begin
            got_q.push_back(tx_data);
            trmt_cnt++;
        end
        if (dump_done === 1'b1) done_cnt++;
        if (dump_err === 1'b1) err_cnt++;
        if (ram_addr >= 9'd384) addr_bad++;
    end

    // UART: tx_done arrives 1+dly cycles after trmt; a trmt while busy is an overlap.
    initial begin
        int dly;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (trmt === 1'b1) begin
                if (tx_mode == 2) dly = int'($urandom_range(50, 0));
                else if (tx_mode == 1) dly = 4;
                else dly = 0;
                repeat (dly + 1) begin
                    @(negedge clk);
                    if (trmt === 1'b1) overlap++;
                end
                tx_done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        trmt_cnt = 0;
        done_cnt = 0;
        err_cnt  = 0;
        addr_bad = 0;
        overlap  = 0;
    endtask

    task automatic start_dump(input logic [2:0] ch, input logic [8:0] addr);
        dump_start = 1'b1;
        dump_chan  = ch;
        cap_addr   = addr;
        @(negedge clk);
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dump_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, dump_busy}, 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, dump_done}, 32'd0);
    endtask

    task automatic compare_stream(input int start, input logic [2:0] ch, input string tag);
        int bad = 0;
        logic [8:0] a;
        logic [7:0] e;
        chk({tag, "_count"}, got_q.size(), N);
        for (int i = 0; i < got_q.size(); i++) begin
            a = 9'((start + i) % N);
            e = a[7:0] ^ {ch, 5'd0} ^ 8'h40;
            if (got_q[i] !== e) bad++;
        end
        chk({tag, "_bytes_bad"}, bad, 0);
        chk({tag, "_addr_range"}, addr_bad, 0);
        chk({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1; dump_start = 1'b0; dump_chan = 3'd0; cap_addr = 9'd0;
        cap_we = 1'b0; cap_waddr = 9'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, dump_busy}, 32'd0);
        chk("rst_trmt", {31'd0, trmt}, 32'd0);
        chk("rst_re", {31'd0, ram_re}, 32'd0);
        chk("rst_done_err", {30'd0, dump_done, dump_err}, 32'd0);
        chk("rst_txdata_chsel", {21'd0, tx_data, ch_sel}, 32'd0);
        chk("rst_addr", {23'd0, ram_addr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: channel 2 from address 0, latency checks
        clear_mon();
        start_dump(3'd2, 9'd0);
        chk("t1_busy", {31'd0, dump_busy}, 32'd1);
        chk("t1_re", {31'd0, ram_re}, 32'd1);
        chk("t1_addr", {23'd0, ram_addr}, 32'd0);
        chk("t1_chsel", {29'd0, ch_sel}, 32'd2);
        @(negedge clk);
        chk("t1_re_pulse", {31'd0, ram_re}, 32'd0);
        chk("t1_trmt_early", {31'd0, trmt}, 32'd0);
        @(negedge clk);
        chk("t1_trmt", {31'd0, trmt}, 32'd1);
        chk("t1_txdata", {24'd0, tx_data}, 32'd0);
        wait_done(5000, "t1");
        compare_stream(0, 3'd2, "t1");

        // 2: start near the end, wrap at 383 -> 0
        clear_mon();
        start_dump(3'd2, 9'd380);
        chk("t2_addr", {23'd0, ram_addr}, 32'd380);
        wait_done(5000, "t2");
        compare_stream(380, 3'd2, "t2");

        // 3: capture steals the port for three RD cycles
        clear_mon();
        cap_we = 1'b1; cap_waddr = 9'h155;
        start_dump(3'd1, 9'd100);
        for (int i = 0; i < 3; i++) begin
            chk("t3_re_blocked", {31'd0, ram_re}, 32'd0);
            chk("t3_addr_cap", {23'd0, ram_addr}, 32'h155);
            chk("t3_we", {31'd0, ram_we}, 32'd1);
            @(negedge clk);
        end
        cap_we = 1'b0;
        #1;
        chk("t3_re_resume", {31'd0, ram_re}, 32'd1);
        chk("t3_addr_resume", {23'd0, ram_addr}, 32'd100);
        chk("t3_we_off", {31'd0, ram_we}, 32'd0);
        wait_done(5000, "t3");
        compare_stream(100, 3'd1, "t3");

        // 4: dump_start while busy, then an illegal channel
        clear_mon();
        start_dump(3'd3, 9'd0);
        n = 0;
        while (trmt_cnt < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        start_dump(3'd0, 9'd200);
        chk("t4_err_busy", {31'd0, dump_err}, 32'd1);
        chk("t4_still_busy", {31'd0, dump_busy}, 32'd1);
        chk("t4_chsel_kept", {29'd0, ch_sel}, 32'd3);
        wait_done(5000, "t4");
        compare_stream(0, 3'd3, "t4");
        chk("t4_err_cnt", err_cnt, 1);
        start_dump(3'd7, 9'd0);
        chk("t4_err_chan", {31'd0, dump_err}, 32'd1);
        chk("t4_chan_not_busy", {31'd0, dump_busy}, 32'd0);
        chk("t4_chan_no_re", {31'd0, ram_re}, 32'd0);
        @(negedge clk);
        chk("t4_err_pulse", {31'd0, dump_err}, 32'd0);
        chk("t4_chsel_unchanged", {29'd0, ch_sel}, 32'd3);

        // 5: reset in WAIT_TX after byte 10
        tx_mode = 1;
        clear_mon();
        start_dump(3'd1, 9'd50);
        n = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (trmt === 1'b1) n++;
            if (n == 11) break;
        end
        chk("t5_reached", n, 11);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", {31'd0, dump_busy}, 32'd0);
        chk("t5_trmt_re", {30'd0, trmt, ram_re}, 32'd0);
        chk("t5_done_err", {30'd0, dump_done, dump_err}, 32'd0);
        chk("t5_txdata_chsel", {21'd0, tx_data, ch_sel}, 32'd0);
        chk("t5_addr", {23'd0, ram_addr}, 32'd0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("t5_no_more_trmt", trmt_cnt, 11);
        chk("t5_no_done", done_cnt, 0);
        chk("t5_idle", {31'd0, dump_busy}, 32'd0);

        // 5b: out-of-range start address restarts at 0
        tx_mode = 0;
        clear_mon();
        start_dump(3'd2, 9'd500);
        chk("t5b_addr_clamp", {23'd0, ram_addr}, 32'd0);
        chk("t5b_re", {31'd0, ram_re}, 32'd1);
        wait_done(5000, "t5b");
        compare_stream(0, 3'd2, "t5b");

        // 6: random UART latency, start at the last address
        tx_mode = 2;
        clear_mon();
        start_dump(3'd4, 9'd383);
        chk("t6_addr", {23'd0, ram_addr}, 32'd383);
        wait_done(30000, "t6");
        compare_stream(383, 3'd4, "t6");
        chk("t6_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
